// File: rtl/sipo_rx_pkg.sv
// sipo_rx_pkg: shared state encoding, default width and counter sizing for the SIPO receiver
package sipo_rx_pkg;

   typedef logic [1:0] sipo_state_t;

   localparam sipo_state_t IDLE   = 2'd0;
   localparam sipo_state_t SHIFT  = 2'd1;
   localparam sipo_state_t PARITY = 2'd2;

   localparam int SIPO_DEFAULT_WIDTH = 4;

   function automatic int sipo_cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/sipo_hold_reg.sv
// sipo_hold_reg: output holding register with valid/ready handshake and overrun detection
module sipo_hold_reg #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             load_perr,
   input  logic             out_ready,
   output logic [WIDTH-1:0] data_out,
   output logic             out_valid,
   output logic             parity_err,
   output logic             overrun
);

   logic take;

   assign take = load & (~out_valid | out_ready);

   // accept a finished word when the slot is free or being drained, otherwise flag the drop
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         data_out   <= '0;
         out_valid  <= 1'b0;
         parity_err <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         overrun <= load & out_valid & ~out_ready;
         if (take) begin
            data_out   <= load_data;
            parity_err <= load_perr;
            out_valid  <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/sipo_receiver.sv
// sipo_receiver: serial-in parallel-out word receiver, LSB first, sync framed; SIPO_PARITY_CHECK_EN adds an even-parity bit per frame
module sipo_receiver
   import sipo_rx_pkg::*;
#(
   parameter int WIDTH = SIPO_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             sh_ena,
   input  logic             sync,
   input  logic             data_in,
   input  logic             out_ready,
   output logic [WIDTH-1:0] data_out,
   output logic             out_valid,
   output logic             parity_err,
   output logic             overrun,
   output logic             frame_err,
   output logic             busy
);

   localparam int CW = sipo_cnt_width(WIDTH);

`ifdef SIPO_PARITY_CHECK_EN
   localparam sipo_state_t AFTER_DATA = PARITY;
`else
   localparam sipo_state_t AFTER_DATA = IDLE;
`endif

   sipo_state_t      state;
   logic [WIDTH-1:0] sr;
   logic [CW-1:0]    cnt;
   logic             last_data;
   logic             load;
   logic [WIDTH-1:0] load_data;
   logic             load_perr;

   assign last_data = sh_ena & ~sync & (state == SHIFT) & (cnt == CW'(WIDTH - 1));
   assign busy      = state != IDLE;

`ifdef SIPO_PARITY_CHECK_EN
   // the parity bit closes the frame; the word itself is already complete in sr
   assign load      = sh_ena & ~sync & (state == PARITY);
   assign load_data = sr;
   assign load_perr = ^sr ^ data_in;
`else
   // the last data bit closes the frame, so hand over the word with that bit merged in
   assign load      = last_data;
   assign load_data = {data_in, sr[WIDTH-1:1]};
   assign load_perr = 1'b0;
`endif

   // framing FSM and shift register; sync always restarts a word, even mid-frame
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state     <= IDLE;
         sr        <= '0;
         cnt       <= '0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= sh_ena & sync & (state != IDLE);
         if (sh_ena & sync) begin
            state <= SHIFT;
            sr    <= {data_in, sr[WIDTH-1:1]};
            cnt   <= CW'(1);
         end else if (sh_ena & (state == SHIFT)) begin
            sr    <= {data_in, sr[WIDTH-1:1]};
            cnt   <= last_data ? '0 : cnt + 1'b1;
            state <= last_data ? AFTER_DATA : SHIFT;
         end else if (load) begin
            state <= IDLE;
         end
      end
   end

   sipo_hold_reg #(.WIDTH(WIDTH)) u_hold (
      .clk        (clk),
      .clr_n      (clr_n),
      .load       (load),
      .load_data  (load_data),
      .load_perr  (load_perr),
      .out_ready  (out_ready),
      .data_out   (data_out),
      .out_valid  (out_valid),
      .parity_err (parity_err),
      .overrun    (overrun)
   );

endmodule

// File: doc/sipo_receiver.md
# sipo_receiver

Serial-in, parallel-out word receiver, the receive end of the 4-bit PISO serial link. It samples one serial bit per `sh_ena` strobe, LSB first, and frames words with a `sync` marker. It presents each completed word on a parallel output with a valid/ready handshake. It sits between the serial link pins and downstream parallel consumers.

## Interface
- `WIDTH`, default 4: data bits per word; legal range 2..32.
- `clk` input, 1 bit: clock; all state updates on the rising edge.
- `clr_n` input, 1 bit: reset, asynchronous, active-low.
- `sh_ena` input, 1 bit: bit strobe; `data_in` is sampled only on cycles where this is high.
- `sync` input, 1 bit: qualified by `sh_ena`; marks the current bit as bit 0 of a new word.
- `data_in` input, 1 bit: serial data, LSB first.
- `out_ready` input, 1 bit: downstream accepts the word held on `data_out`.
- `data_out` output, `WIDTH` bits: received word; stable while `out_valid` is high.
- `out_valid` output, 1 bit: holding register contains an unconsumed word.
- `parity_err` output, 1 bit: parity mismatch flag for the word on `data_out`; meaningful only while `out_valid` is high.
- `overrun` output, 1 bit: one-cycle pulse when a completed word is dropped.
- `frame_err` output, 1 bit: one-cycle pulse when `sync` restarts a partially received word.
- `busy` output, 1 bit: a word is partially received.

## Operation
- Reset values: all outputs 0, shift register 0, bit counter 0, state IDLE.
- Shift register update on every accepted bit: `sr <= {data_in, sr[WIDTH-1:1]}`. After `WIDTH` bits, the first-received bit is in `sr[0]`.
- **IDLE state**
  - `sh_ena & sync`: capture the bit, set count to 1, go to SHIFT.
  - `sh_ena` without `sync`: bit discarded; remain in IDLE.
- **SHIFT state**
  - `sh_ena & ~sync`: shift the bit in and increment the count.
  - `sh_ena & sync`: discard the partial word, pulse `frame_err`, capture the bit as the new bit 0, set count to 1.
  - When the accepted bit makes count equal `WIDTH`, the word is complete. Without parity, perform a transfer and go to IDLE. With parity, go to PARITY.
- **PARITY state** (compiled only with the parity feature)
  - `sh_ena & ~sync`: the bit is even parity over the word. Perform a transfer with `parity_err = ^sr ^ data_in`, then go to IDLE.
  - `sh_ena & sync`: same restart rule as in SHIFT; the word is discarded.
- **Transfer**
  - If `~out_valid`, or `out_valid & out_ready` in the same cycle: load `data_out` and `parity_err`, set `out_valid`.
  - Otherwise: drop the new word, pulse `overrun`; the old word and its flag are unchanged.
- **Handshake**
  - `out_valid & out_ready` with no transfer in the same cycle clears `out_valid` on the next edge.
  - A consume and a transfer in the same cycle leave `out_valid` high, with the new word visible next cycle.
  - `data_out` holds its last value after being consumed.
- `busy` is high in SHIFT and PARITY.
- Reset asserted mid-word returns to the reset state immediately. A pending partial word or an unconsumed word is lost.

## Timing
- Latency: the edge that samples the last bit (data bit or parity bit) sets `out_valid` and `data_out`. Both are visible in the following cycle.
- Strobes may be back-to-back, one bit per clock, or sparse. Cycles with `sh_ena` low leave all state unchanged.
- `overrun` and `frame_err` are registered, high for exactly one cycle per event.
- No combinational path from any input to any output.

## Configuration
- Macro `SIPO_PARITY_CHECK_EN`.
- Defined: a frame is `WIDTH` data bits plus one even-parity bit. The PARITY state exists and `parity_err` is computed per word.
- Undefined: a frame is `WIDTH` bits and there is no PARITY state. `parity_err` is a constant 0.

## Structure
- Package `sipo_rx_pkg` holds:
  - the state encoding typedef (`IDLE`, `SHIFT`, `PARITY`);
  - `SIPO_DEFAULT_WIDTH = 4`;
  - the bit-counter width function `$clog2(WIDTH+1)`.
- One sub-module, `sipo_hold_reg`, implements the output holding register. It owns the valid/ready handshake, the overrun decision, and the `data_out`/`parity_err` registers. The FSM and shift register live in the top module.

## Test plan
- Reset release, then `sync` and bits 1,1,0,1 on consecutive strobes with `out_ready=1` -> `data_out=4'hB`, `out_valid` high one cycle after the 4th bit, then low.
- Strobes with `sync` low while in IDLE, then a valid frame 0,1,0,0 -> the first bits are ignored; `data_out=4'h2`; `frame_err` stays 0.
- Two frames 4'h5 then 4'hA with `out_ready=0` -> `data_out` stays 4'h5; `overrun` pulses once when the second word completes. Then `out_ready=1` -> `out_valid` drops.
- After 2 bits, assert `sync` with a new frame 1,0,0,0 -> `frame_err` pulses once; `data_out=4'h1`.
- `out_ready` high in the same cycle a second word completes -> no `overrun`; `out_valid` stays high; `data_out` changes to the new word.
- With `SIPO_PARITY_CHECK_EN`, send frame 1,1,0,1 with parity bit 1 -> `parity_err=0`. With parity bit 0 -> `parity_err=1`. In both cases, `clr_n` asserted mid-frame clears all outputs.
